// File: rtl/rr_resource_scheduler_if.sv
// rr_resource_scheduler_if: requester/scheduler bundle for the round-robin resource scheduler.
//   req      requester -> scheduler  one request level per requester
//   lock     requester -> scheduler  owner blocks preemption while high
//   grant    scheduler -> requester  one-hot registered grant
//   grant_id scheduler -> requester  index of current owner (valid while busy)
//   busy     scheduler -> requester  any grant bit set
//   preempt  scheduler -> requester  pulse in the gap after a forced release
//   stall    scheduler -> requester  some requester is waiting
interface rr_resource_scheduler_if #(
    parameter int NUM_REQ = 4
);
    localparam int ID_W = $clog2(NUM_REQ);
    logic [NUM_REQ-1:0] req;
    logic               lock;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grant_id;
    logic               busy;
    logic               preempt;
    logic               stall;
    modport master (output req, lock, input grant, grant_id, busy, preempt, stall);
    modport slave  (input req, lock, output grant, grant_id, busy, preempt, stall);
endinterface

// File: rtl/rr_resource_scheduler.sv
// rr_resource_scheduler: N-way round-robin scheduler for one shared pipeline resource.
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    slave side of rr_resource_scheduler_if (req/lock in; grant/grant_id/busy/preempt/stall out)
module rr_resource_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int MAX_HOLD = 8
) (
    input logic                    clk,
    input logic                    reset,
    rr_resource_scheduler_if.slave bus
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int HW   = $clog2(MAX_HOLD + 2);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
    state_t             state;
    logic [NUM_REQ-1:0] grant_q;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    last;
    logic               busy_q;
    logic               preempt_q;
    logic [HW-1:0]      hold_cnt;
    logic               found;
    logic [ID_W-1:0]    pick;
    logic               owner_req;
    logic               contended;
    logic               at_limit;
    // Scan from the farthest candidate down to last+1 so the nearest one in
    // round-robin order wins; the previous owner (last) is considered last.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (bus.req[(int'(last) + i) % NUM_REQ]) begin
                found = 1'b1;
                pick  = ID_W'((int'(last) + i) % NUM_REQ);
            end
        end
    end
    assign owner_req = bus.req[id_q];
    assign contended = |(bus.req & ~grant_q);
    assign at_limit  = (MAX_HOLD != 0) && (hold_cnt == HW'(MAX_HOLD));
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            grant_q   <= '0;
            id_q      <= '0;
            last      <= ID_W'(NUM_REQ - 1);
            busy_q    <= 1'b0;
            preempt_q <= 1'b0;
            hold_cnt  <= '0;
        end else begin
            preempt_q <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    if (found) begin
                        state    <= GRANT;
                        grant_q  <= NUM_REQ'(1) << pick;
                        id_q     <= pick;
                        last     <= pick;
                        busy_q   <= 1'b1;
                        hold_cnt <= HW'(1);
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    // An owner dropping req always releases normally, even at the limit;
                    // preempt is flagged only when the owner is still requesting.
                    if (!owner_req || (at_limit && !bus.lock && contended)) begin
                        state     <= GAP;
                        grant_q   <= '0;
                        busy_q    <= 1'b0;
                        preempt_q <= owner_req;
                    end else if (hold_cnt < HW'(MAX_HOLD)) begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end
    assign bus.grant    = grant_q;
    assign bus.grant_id = id_q;
    assign bus.busy     = busy_q;
    assign bus.preempt  = preempt_q;
    assign bus.stall    = |(bus.req & ~grant_q);
endmodule

// File: tb/tb_rr_resource_scheduler.sv
// tb_rr_resource_scheduler: directed scoreboard bench for rr_resource_scheduler (NUM_REQ=4, MAX_HOLD=4).
module tb_rr_resource_scheduler;
    localparam int N  = 4;
    localparam int MH = 4;
    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic       p;
    } exp_t;
    logic clk = 1'b0;
    logic reset;
    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    always #5 clk = ~clk;
    rr_resource_scheduler_if #(.NUM_REQ(N)) bus ();
    rr_resource_scheduler #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );
    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    function automatic logic [1:0] idx_of(input logic [3:0] g);
        idx_of = 2'd0;
        for (int i = 0; i < 4; i++) if (g[i]) idx_of = 2'(i);
    endfunction
    // Drive one cycle of inputs, queue the expected response, compare after the edge.
    task automatic cyc(input logic [3:0] r, input logic l, input logic [3:0] eg, input logic ep, input string tag);
        exp_t e;
        bus.req  = r;
        bus.lock = l;
        sbq.push_back('{r: r, g: eg, p: ep});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check({tag, ".grant"}, {4'b0, bus.grant}, {4'b0, e.g});
        check({tag, ".preempt"}, {7'b0, bus.preempt}, {7'b0, e.p});
        check({tag, ".busy"}, {7'b0, bus.busy}, {7'b0, |e.g});
        check({tag, ".stall"}, {7'b0, bus.stall}, {7'b0, |(e.r & ~e.g)});
        if (|e.g) check({tag, ".grant_id"}, {6'b0, bus.grant_id}, {6'b0, idx_of(e.g)});
    endtask
    task automatic do_reset();
        reset    = 1'b1;
        bus.req  = '0;
        bus.lock = 1'b0;
        @(posedge clk);
        #1;
        check("rst.grant", {4'b0, bus.grant}, 8'h00);
        check("rst.busy", {7'b0, bus.busy}, 8'h00);
        check("rst.preempt", {7'b0, bus.preempt}, 8'h00);
        reset = 1'b0;
    endtask
    initial begin
        reset    = 1'b1;
        bus.req  = '0;
        bus.lock = 1'b0;
        do_reset();
        // 1: single requester after reset
        cyc(4'b0001, 1'b0, 4'b0001, 1'b0, "t1");
        cyc(4'b0000, 1'b0, 4'b0000, 1'b0, "t1_rel");
        cyc(4'b0000, 1'b0, 4'b0000, 1'b0, "t1_idle");
        // 2: full contention rotates with forced releases
        do_reset();
        for (int k = 0; k < 5; k++) begin
            for (int c = 0; c < 4; c++) cyc(4'b1111, 1'b0, 4'(1 << (k % 4)), 1'b0, "t2_grant");
            if (k < 4) cyc(4'b1111, 1'b0, 4'b0000, 1'b1, "t2_gap");
        end
        cyc(4'b0000, 1'b0, 4'b0000, 1'b0, "t2_rel_at_limit");
        cyc(4'b0000, 1'b0, 4'b0000, 1'b0, "t2_idle");
        // 3: lone requester is never preempted
        for (int c = 0; c < 20; c++) cyc(4'b0100, 1'b0, 4'b0100, 1'b0, "t3");
        cyc(4'b0000, 1'b0, 4'b0000, 1'b0, "t3_rel");
        cyc(4'b0000, 1'b0, 4'b0000, 1'b0, "t3_idle");
        // 4: lock defers preemption
        for (int c = 0; c < 8; c++) cyc(4'b0011, 1'b1, 4'b0001, 1'b0, "t4_lock");
        cyc(4'b0011, 1'b0, 4'b0000, 1'b1, "t4_gap");
        cyc(4'b0011, 1'b0, 4'b0010, 1'b0, "t4_next");
        // 5: owner drops req while another waits; waiting req[0] withdraws
        cyc(4'b1010, 1'b0, 4'b0010, 1'b0, "t5_hold");
        cyc(4'b1000, 1'b0, 4'b0000, 1'b0, "t5_gap");
        cyc(4'b1000, 1'b0, 4'b1000, 1'b0, "t5_next");
        // sole remaining requester is regranted after a forced release
        for (int c = 0; c < 3; c++) cyc(4'b1001, 1'b0, 4'b1000, 1'b0, "t5b_hold");
        cyc(4'b1001, 1'b0, 4'b0000, 1'b1, "t5b_gap");
        cyc(4'b1000, 1'b0, 4'b1000, 1'b0, "t5b_regrant");
        // 6: asynchronous reset while grant=0100
        cyc(4'b0000, 1'b0, 4'b0000, 1'b0, "t6_rel");
        cyc(4'b0100, 1'b0, 4'b0100, 1'b0, "t6_grant");
        reset   = 1'b1;
        bus.req = 4'b1010;
        #1;
        check("t6_async.grant", {4'b0, bus.grant}, 8'h00);
        check("t6_async.busy", {7'b0, bus.busy}, 8'h00);
        @(posedge clk);
        #1;
        check("t6_held.grant", {4'b0, bus.grant}, 8'h00);
        reset = 1'b0;
        cyc(4'b1010, 1'b0, 4'b0010, 1'b0, "t6_after");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
